// File: rtl/shift_exec_stage.sv
// Registered execute-stage shift unit: SLL / SRA / ROR on a 16-bit operand,
// two-register (operand, result) pipeline with valid/ready on both sides.
module shift_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_z,
  output logic             out_n,
  output logic             out_err
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_data;
  logic [3:0]       s1_shamt;

  logic             s2_adv;
  logic             accept;

  logic [WIDTH-1:0] ror_1, ror_2, ror_4, ror_8;
  logic [WIDTH-1:0] result;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Rotate right as four power-of-two stages, one per shamt bit.
  assign ror_1 = s1_shamt[0] ? {s1_data[0],   s1_data[WIDTH-1:1]} : s1_data;
  assign ror_2 = s1_shamt[1] ? {ror_1[1:0],   ror_1[WIDTH-1:2]}   : ror_1;
  assign ror_4 = s1_shamt[2] ? {ror_2[3:0],   ror_2[WIDTH-1:4]}   : ror_2;
  assign ror_8 = s1_shamt[3] ? {ror_4[7:0],   ror_4[WIDTH-1:8]}   : ror_4;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    result = s1_data;
    unique case (s1_op)
      OP_SLL:  result = s1_data << s1_shamt;
      OP_SRA:  result = WIDTH'($signed(s1_data) >>> s1_shamt);
      OP_ROR:  result = ror_8;
      OP_ILL:  result = s1_data;
      default: result = s1_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the operand payload is left unreset; it is only observed while
  // s1_valid is set, which does reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op    <= op_e'(in_op);
      s1_data  <= in_data;
      s1_shamt <= in_shamt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register: the whole payload holds while stalled by out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_z     <= (result == '0);
      out_n     <= result[WIDTH-1];
      out_err   <= (s1_op == OP_ILL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vector table, streaming,
// backpressure and mid-flight reset, with a scoreboard queue on the output.
module tb_shift_exec_stage;

  typedef struct packed {
    logic [15:0] d;
    logic        z;
    logic        n;
    logic        err;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  shamt;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_shamt = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_z;
  logic        out_n;
  logic        out_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_acc  = 0;
  res_t exp_cur = '0;
  res_t mon_e;
  res_t sb[$];

  shift_exec_stage #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_z    (out_z),
    .out_n    (out_n),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Bit-serial reference: one single-bit shift per unit of shamt.
  function automatic res_t model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (op)
        2'b00:   r = {r[14:0], 1'b0};
        2'b01:   r = {r[15], r[15:1]};
        2'b10:   r = {r[0], r[15:1]};
        default: r = r;
      endcase
    end
    return '{d: r, z: (r == 16'h0), n: r[15], err: (op == 2'b11)};
  endfunction

  // Handshakes are evaluated at the falling edge, half a cycle before the
  // rising edge where they take effect; output pops precede input pushes.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hDEAD);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.d));
          check("out_z",    32'(out_z),    32'(mon_e.z));
          check("out_n",    32'(out_n),    32'(mon_e.n));
          check("out_err",  32'(out_err),  32'(mon_e.err));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_cur);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s, input res_t e);
    int cyc;
    bit acc;
    cyc = 0;
    acc = 0;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    exp_cur  = e;
    in_valid = 1'b1;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[12];
  res_t stall_exp;
  int   acc_base;

  initial begin
    vecs[0]  = '{2'b10, 16'h8001, 4'd1,  '{16'hC000, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{2'b10, 16'h1234, 4'd4,  '{16'h4123, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{2'b10, 16'h1234, 4'd0,  '{16'h1234, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{2'b01, 16'h8000, 4'd15, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{2'b00, 16'h0001, 4'd15, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{2'b00, 16'h8000, 4'd1,  '{16'h0000, 1'b1, 1'b0, 1'b0}};
    vecs[6]  = '{2'b11, 16'h00F0, 4'd5,  '{16'h00F0, 1'b0, 1'b0, 1'b1}};
    vecs[7]  = '{2'b00, 16'h00F0, 4'd4,  '{16'h0F00, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{2'b01, 16'h7000, 4'd4,  '{16'h0700, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{2'b01, 16'hF000, 4'd4,  '{16'hFF00, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{2'b10, 16'h0001, 4'd15, '{16'h0002, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{2'b00, 16'hABCD, 4'd0,  '{16'hABCD, 1'b0, 1'b1, 1'b0}};

    // Reset state while rst is held
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_flags", 32'({out_z, out_n, out_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 12; i++) send(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);
    drain();

    // Streaming: 8 back-to-back ops
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        in_op    = 2'($urandom_range(0, 2));
        in_data  = 16'($urandom);
        in_shamt = 4'($urandom);
        exp_cur  = model(in_op, in_data, in_shamt);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'(k >= 2));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stream_out_valid_end", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: third op must wait for out_ready
    out_ready = 1'b0;
    acc_base  = n_acc;
    stall_exp = model(2'b00, 16'h0123, 4'd3);
    send(2'b00, 16'h0123, 4'd3, stall_exp);
    send(2'b01, 16'h9876, 4'd2, model(2'b01, 16'h9876, 4'd2));
    in_op    = 2'b10;
    in_data  = 16'h5A5A;
    in_shamt = 4'd7;
    exp_cur  = model(2'b10, 16'h5A5A, 4'd7);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'(stall_exp.d));
      @(posedge clk);
      #1;
      in_data = 16'(in_data + 16'h1111);
    end
    in_data = 16'h5A5A;
    check("bp_accepted_two", 32'(n_acc - acc_base), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("bp_accepted_three", 32'(n_acc - acc_base), 32'd3);

    // Reset with S1 and S2 both full
    out_ready = 1'b0;
    send(2'b00, 16'h1111, 4'd1, model(2'b00, 16'h1111, 4'd1));
    send(2'b00, 16'h2222, 4'd1, model(2'b00, 16'h2222, 4'd1));
    check("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      check("post_rst_ready",    32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
    end
    send(2'b10, 16'hF00F, 4'd8, model(2'b10, 16'hF00F, 4'd8));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
